// File: rtl/pico_riscv_core.sv
// ---------------------------------------------------------------------------
// pico_riscv_core
//
// Purpose:
//   8-bit educational RISC-style CPU. Eight 8-bit registers (r0 reads zero),
//   8-bit program counter and 16-bit instructions fetched from an external
//   instruction memory addressed by pc. A two-phase FETCH/EXECUTE sequencer
//   runs every instruction in exactly two enabled clock cycles.
//
// Ports:
//   clk               in   1   clock, all state updates on the rising edge
//   rst               in   1   synchronous reset, active-high (beats ena)
//   ena               in   1   clock enable, low freezes every register
//   instr_in          in  16   instruction word at address pc (read in FETCH)
//   in_port           in   8   external input read by IN
//   pc                out  8   program counter / instruction address
//   instruction_reg   out 16   latched current instruction
//   instruction_valid out  1   high during EXECUTE (instruction_reg is live)
//   branch_taken      out  1   high for the FETCH cycle after a taken
//                              BEQ/BNE or a JMP
//   alu_result        out  8   last ALU / writeback value
//   out_port          out  8   register value written by OUT
//   halted            out  1   sticky after HALT, cleared only by rst
//
// Optional feature (macro PICO_DBG_EN):
//   dbg_sel           in   3   register index to observe
//   dbg_data          out  8   combinational reg[dbg_sel], r0 reads 0
//
// Handshake: none. instr_in is assumed valid combinationally from pc at the
// FETCH edge; there is no stall/ready path other than ena.
// ---------------------------------------------------------------------------
module pico_riscv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] instr_in,
    input  logic [7:0]  in_port,
`ifdef PICO_DBG_EN
    input  logic [2:0]  dbg_sel,
    output logic [7:0]  dbg_data,
`endif
    output logic [7:0]  pc,
    output logic [15:0] instruction_reg,
    output logic        instruction_valid,
    output logic        branch_taken,
    output logic [7:0]  alu_result,
    output logic [7:0]  out_port,
    output logic        halted
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Architectural and sequencer state
    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic        r_valid;
    logic        r_branch_taken;
    logic [7:0]  r_alu;
    logic [7:0]  r_out;
    logic        r_halted;
    logic [7:0]  r_regs [8];

    // Decode fields of the latched instruction
    logic [3:0]  w_op;
    logic [2:0]  w_f_hi;    // rd (R/I-type), rs1 (branch)
    logic [2:0]  w_f_mid;   // rs1 (R-type), rs2 (branch)
    logic [2:0]  w_f_lo;    // rs2 (R-type)
    logic [7:0]  w_imm8;
    logic [7:0]  w_off8;    // sign-extended branch offset

    // Operand reads
    logic [7:0]  w_v_hi;
    logic [7:0]  w_v_mid;
    logic [7:0]  w_v_lo;

    // Execute results
    logic        w_wr_en;
    logic [7:0]  w_wr_val;
    logic        w_alu_upd;
    logic [7:0]  w_alu_val;
    logic        w_out_upd;
    logic        w_taken;
    logic        w_halt_now;
    logic [7:0]  w_pc_inc;
    logic [7:0]  w_pc_next;

    function automatic logic [7:0] read_reg(input logic [2:0] idx,
                                            input logic [7:0] v);
        return (idx == 3'd0) ? 8'h00 : v;
    endfunction

    assign w_op    = r_ir[15:12];
    assign w_f_hi  = r_ir[11:9];
    assign w_f_mid = r_ir[8:6];
    assign w_f_lo  = r_ir[5:3];
    assign w_imm8  = r_ir[7:0];
    assign w_off8  = {{2{r_ir[5]}}, r_ir[5:0]};

    assign w_v_hi  = read_reg(w_f_hi,  r_regs[w_f_hi]);
    assign w_v_mid = read_reg(w_f_mid, r_regs[w_f_mid]);
    assign w_v_lo  = read_reg(w_f_lo,  r_regs[w_f_lo]);

    assign w_pc_inc = r_pc + 8'd1;

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_val   = 8'h00;
        w_alu_upd  = 1'b0;
        w_alu_val  = 8'h00;
        w_out_upd  = 1'b0;
        w_taken    = 1'b0;
        w_halt_now = 1'b0;
        w_pc_next  = w_pc_inc;

        case (w_op)
            OP_ADD:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid + w_v_lo; end
            OP_SUB:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid - w_v_lo; end
            OP_AND:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid & w_v_lo; end
            OP_OR:   begin w_wr_en = 1'b1; w_wr_val = w_v_mid | w_v_lo; end
            OP_XOR:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid ^ w_v_lo; end
            OP_SLL:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid << w_v_lo[2:0]; end
            OP_SRL:  begin w_wr_en = 1'b1; w_wr_val = w_v_mid >> w_v_lo[2:0]; end
            OP_LI:   begin w_wr_en = 1'b1; w_wr_val = w_imm8; end
            OP_ADDI: begin w_wr_en = 1'b1; w_wr_val = w_v_hi + w_imm8; end
            OP_IN:   begin w_wr_en = 1'b1; w_wr_val = in_port; end
            OP_BEQ, OP_BNE: begin
                // Compare result is published even when the branch falls through
                w_alu_upd = 1'b1;
                w_alu_val = w_v_hi - w_v_mid;
                w_taken   = (w_op == OP_BEQ) ? (w_v_hi == w_v_mid)
                                             : (w_v_hi != w_v_mid);
                if (w_taken) begin
                    // Relative to the branch's own address; wraps mod 256
                    w_pc_next = r_pc + w_off8;
                end
            end
            OP_JMP: begin
                w_taken   = 1'b1;
                w_pc_next = w_imm8;
            end
            OP_OUT:  w_out_upd = 1'b1;
            OP_HALT: begin
                w_halt_now = 1'b1;
                w_pc_next  = r_pc;
            end
            default: ;   // OP_NOP
        endcase

        // Writeback value doubles as the ALU result for all writing ops
        if (w_wr_en) begin
            w_alu_upd = 1'b1;
            w_alu_val = w_wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_FETCH;
            r_pc           <= 8'h00;
            r_ir           <= 16'h0000;
            r_valid        <= 1'b0;
            r_branch_taken <= 1'b0;
            r_alu          <= 8'h00;
            r_out          <= 8'h00;
            r_halted       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (ena) begin
            case (r_state)
                ST_FETCH: begin
                    r_ir           <= instr_in;
                    r_valid        <= 1'b1;
                    r_branch_taken <= 1'b0;
                    r_state        <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_valid <= 1'b0;
                    r_state <= ST_FETCH;
                    // Once halted, whatever is fetched behaves as HALT: no
                    // architectural state moves until reset.
                    if (r_halted) begin
                        r_branch_taken <= 1'b0;
                    end else begin
                        r_pc           <= w_pc_next;
                        r_branch_taken <= w_taken;
                        if (w_wr_en && (w_f_hi != 3'd0)) begin
                            r_regs[w_f_hi] <= w_wr_val;
                        end
                        if (w_alu_upd) begin
                            r_alu <= w_alu_val;
                        end
                        if (w_out_upd) begin
                            r_out <= w_v_hi;
                        end
                        if (w_halt_now) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign pc                = r_pc;
    assign instruction_reg   = r_ir;
    assign instruction_valid = r_valid;
    assign branch_taken      = r_branch_taken;
    assign alu_result        = r_alu;
    assign out_port          = r_out;
    assign halted            = r_halted;

`ifdef PICO_DBG_EN
    assign dbg_data = read_reg(dbg_sel, r_regs[dbg_sel]);
`endif

endmodule

// File: tb/tb_pico_riscv_core.sv
module tb_pico_riscv_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] instr_in;
  logic [7:0]  in_port;
  logic [7:0]  pc;
  logic [15:0] instruction_reg;
  logic        instruction_valid;
  logic        branch_taken;
  logic [7:0]  alu_result;
  logic [7:0]  out_port;
  logic        halted;

  int total = 0;
  int bad   = 0;

  pico_riscv_core dut (
    .clk               (clk),
    .rst               (rst),
    .ena               (ena),
    .instr_in          (instr_in),
    .in_port           (in_port),
    .pc                (pc),
    .instruction_reg   (instruction_reg),
    .instruction_valid (instruction_valid),
    .branch_taken      (branch_taken),
    .alu_result        (alu_result),
    .out_port          (out_port),
    .halted            (halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  int m_pc;
  int m_reg[8];
  int m_alu;
  int m_out;
  int m_bt;
  int m_halt;

  task automatic m_reset();
    m_pc = 0; m_alu = 0; m_out = 0; m_bt = 0; m_halt = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
  endtask

  task automatic m_write(input int rd, input int v);
    m_alu = v & 255;
    if (rd != 0) m_reg[rd] = v & 255;
  endtask

  task automatic m_exec(input logic [15:0] ins, input int inp);
    int op, a, b, c, imm, off, npc;
    op  = int'(ins[15:12]);
    a   = int'(ins[11:9]);
    b   = int'(ins[8:6]);
    c   = int'(ins[5:3]);
    imm = int'(ins[7:0]);
    off = int'(ins[5:0]);
    if (off >= 32) off = off - 64;
    m_bt = 0;
    if (m_halt != 0) return;
    npc = (m_pc + 1) % 256;
    case (op)
      1:  m_write(a, m_reg[b] + m_reg[c]);
      2:  m_write(a, m_reg[b] - m_reg[c] + 256);
      3:  m_write(a, m_reg[b] & m_reg[c]);
      4:  m_write(a, m_reg[b] | m_reg[c]);
      5:  m_write(a, m_reg[b] ^ m_reg[c]);
      6:  m_write(a, m_reg[b] * (1 << (m_reg[c] % 8)));
      7:  m_write(a, m_reg[b] / (1 << (m_reg[c] % 8)));
      8:  m_write(a, imm);
      9:  m_write(a, m_reg[a] + imm);
      10, 11: begin
        m_alu = (m_reg[a] - m_reg[b] + 256) % 256;
        if ((op == 10) == (m_reg[a] == m_reg[b])) begin
          npc  = (m_pc + off + 256) % 256;
          m_bt = 1;
        end
      end
      12: begin npc = imm; m_bt = 1; end
      13: m_write(a, inp);
      14: m_out = m_reg[a];
      15: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ena = 1'b1;
    m_reset();
  endtask

  // One instruction: FETCH edge, optional ena-low hold mid-EXECUTE, EXECUTE edge.
  task automatic step(input logic [15:0] ins, input logic [7:0] inp, input int gap,
                      input logic [7:0] pc_before);
    instr_in = ins;
    in_port  = inp;
    @(posedge clk); #1;
    chk("fetch_valid", 16'(instruction_valid), 16'd1);
    chk("fetch_ir", instruction_reg, ins);
    chk("fetch_bt", 16'(branch_taken), 16'd0);
    chk("fetch_pc", 16'(pc), 16'(pc_before));
    if (gap > 0) begin
      ena = 1'b0;
      instr_in = 16'($urandom);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("hold_pc", 16'(pc), 16'(pc_before));
        chk("hold_valid", 16'(instruction_valid), 16'd1);
        chk("hold_ir", instruction_reg, ins);
      end
      ena = 1'b1;
    end
    @(posedge clk); #1;
    chk("exec_valid", 16'(instruction_valid), 16'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] instr;
    logic [7:0]  inp;
    logic [7:0]  e_pc;
    logic [7:0]  e_alu;
    logic [7:0]  e_out;
    logic        e_bt;
    logic        e_halt;
  } vec_t;

  vec_t tbl[22];

  task automatic check_model(input string tag);
    chk({tag, "_pc"},   16'(pc),           16'(m_pc));
    chk({tag, "_alu"},  16'(alu_result),   16'(m_alu));
    chk({tag, "_out"},  16'(out_port),     16'(m_out));
    chk({tag, "_bt"},   16'(branch_taken), 16'(m_bt));
    chk({tag, "_halt"}, 16'(halted),       16'(m_halt));
  endtask

  initial begin
    logic [7:0]  prev_pc;
    logic [15:0] ins;
    int          r;

    rst = 1'b1; ena = 1'b0; instr_in = 16'h0000; in_port = 8'h00;

    //          instr     in     pc     alu    out    bt    halt
    tbl[0]  = '{16'h8205, 8'h00, 8'h01, 8'h05, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{16'h8403, 8'h00, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{16'h1650, 8'h00, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{16'h2888, 8'h00, 8'h04, 8'hFE, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{16'h80FF, 8'h00, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{16'hA27E, 8'h00, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{16'hB27E, 8'h00, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{16'hE000, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{16'hE600, 8'h00, 8'h06, 8'h00, 8'h08, 1'b0, 1'b0};
    tbl[9]  = '{16'hE800, 8'h00, 8'h07, 8'h00, 8'hFE, 1'b0, 1'b0};
    tbl[10] = '{16'hC0FF, 8'h00, 8'hFF, 8'h00, 8'hFE, 1'b1, 1'b0};
    tbl[11] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0};
    tbl[12] = '{16'hDA00, 8'h5A, 8'h01, 8'h5A, 8'hFE, 1'b0, 1'b0};
    tbl[13] = '{16'hEA00, 8'h00, 8'h02, 8'h5A, 8'h5A, 1'b0, 1'b0};
    tbl[14] = '{16'h7650, 8'h00, 8'h03, 8'h00, 8'h5A, 1'b0, 1'b0};
    tbl[15] = '{16'h6650, 8'h00, 8'h04, 8'h28, 8'h5A, 1'b0, 1'b0};
    tbl[16] = '{16'h9A10, 8'h00, 8'h05, 8'h6A, 8'h5A, 1'b0, 1'b0};
    tbl[17] = '{16'h3D58, 8'h00, 8'h06, 8'h28, 8'h5A, 1'b0, 1'b0};
    tbl[18] = '{16'h5F58, 8'h00, 8'h07, 8'h42, 8'h5A, 1'b0, 1'b0};
    tbl[19] = '{16'h4E50, 8'h00, 8'h08, 8'h07, 8'h5A, 1'b0, 1'b0};
    tbl[20] = '{16'hF000, 8'h00, 8'h08, 8'h07, 8'h5A, 1'b0, 1'b1};
    tbl[21] = '{16'h8205, 8'h00, 8'h08, 8'h07, 8'h5A, 1'b0, 1'b1};

    // ---- reset state (asserted with ena low) ----
    do_reset();
    chk("rst_pc",    16'(pc), 16'h00);
    chk("rst_ir",    instruction_reg, 16'h0000);
    chk("rst_valid", 16'(instruction_valid), 16'd0);
    chk("rst_bt",    16'(branch_taken), 16'd0);
    chk("rst_alu",   16'(alu_result), 16'h00);
    chk("rst_out",   16'(out_port), 16'h00);
    chk("rst_halt",  16'(halted), 16'd0);

    // ---- table-driven directed program ----
    prev_pc = 8'h00;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].instr, tbl[i].inp, 0, prev_pc);
      chk($sformatf("tbl%0d_pc", i),   16'(pc),           16'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_alu", i),  16'(alu_result),   16'(tbl[i].e_alu));
      chk($sformatf("tbl%0d_out", i),  16'(out_port),     16'(tbl[i].e_out));
      chk($sformatf("tbl%0d_bt", i),   16'(branch_taken), 16'(tbl[i].e_bt));
      chk($sformatf("tbl%0d_halt", i), 16'(halted),       16'(tbl[i].e_halt));
      prev_pc = tbl[i].e_pc;
    end
    // branch_taken from the BEQ must drop after its one FETCH cycle: checked by
    // the fetch_bt compare inside the following step.

    // ---- ena low for 5 cycles mid-EXECUTE ----
    do_reset();
    step(16'h8211, 8'h00, 0, 8'h00);            // LI r1,0x11
    chk("ena_pre_alu", 16'(alu_result), 16'h11);
    step(16'h1248, 8'h00, 5, 8'h01);            // ADD r1,r1,r1 with a 5-cycle hold
    chk("ena_pc",  16'(pc), 16'h02);
    chk("ena_alu", 16'(alu_result), 16'h22);

    // ---- reset mid-EXECUTE aborts the instruction (ena low too) ----
    instr_in = 16'h82FF;                        // LI r1,0xFF
    @(posedge clk); #1;
    chk("abort_fetch_valid", 16'(instruction_valid), 16'd1);
    rst = 1'b1; ena = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ena = 1'b1;
    m_reset();
    chk("abort_pc",    16'(pc), 16'h00);
    chk("abort_alu",   16'(alu_result), 16'h00);
    chk("abort_valid", 16'(instruction_valid), 16'd0);
    chk("abort_ir",    instruction_reg, 16'h0000);
    step(16'hE200, 8'h00, 0, 8'h00);            // OUT r1 -> must be 0
    chk("abort_r1", 16'(out_port), 16'h00);
    chk("abort_pc2", 16'(pc), 16'h01);

    // ---- randomized program against the reference model ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom);
      if (n % 2 == 1) ins = {4'hE, 12'(r)};                       // observe a register
      else            ins = {4'($urandom_range(0, 14)), 12'(r)};  // any op but HALT
      prev_pc = 8'(m_pc);
      in_port = 8'($urandom);
      step(ins, in_port, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, prev_pc);
      m_exec(ins, int'(in_port));
      check_model($sformatf("rnd%0d", n));
    end
    // HALT then confirm everything stays frozen
    prev_pc = 8'(m_pc);
    step(16'hF000, 8'h00, 0, prev_pc);
    m_exec(16'hF000, 0);
    check_model("halt");
    for (int n = 0; n < 4; n++) begin
      ins = {4'($urandom_range(1, 14)), 12'($urandom)};
      step(ins, 8'($urandom), 0, prev_pc);
      m_exec(ins, 0);
      check_model($sformatf("frozen%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
